// File: rtl/trig_link_pkg.sv
// Shared definitions for the trigger-tag serial link, used by the transmitter and by the
// digitizer-side receiver: field defaults, framing bits, tx states and the check helpers.
package trig_link_pkg;

    localparam int ID_W_DEFAULT = 8;
    localparam int TS_W_DEFAULT = 56;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_CHECK = 3'd3,
        TX_STOP  = 3'd4,
        TX_GAP   = 3'd5
    } tx_state_e;

    // Bits on the wire for one frame: start + id + timestamp + check + stop.
    function automatic int frame_bits(input int id_w, input int ts_w, input int check_w);
        return 1 + id_w + ts_w + check_w + 1;
    endfunction

    // One bit of a non-reflected CRC-8, bits fed in transmit order.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/trig_tag_fifo.sv
// Small tag FIFO with first-word fall-through read so the transmitter can pop and load
// its shift register in the same cycle.
module trig_tag_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_adc,
    input  logic                     nrst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q[AW-1:0]];
    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/trig_tag_tx.sv
// Trigger-tag serial transmitter: queues {id, timestamp} tags and sends framed LSB-first bits.
// Define TRIG_TAG_TX_CRC8_EN to replace the 1-bit even parity check with an 8-bit CRC-8.
module trig_tag_tx
    import trig_link_pkg::*;
#(
    parameter int ID_W       = ID_W_DEFAULT,
    parameter int TS_W       = TS_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_DIV    = 4,
    parameter int IDLE_BITS  = 2
) (
    input  logic                          clk_adc,
    input  logic                          nrst,
    input  logic                          enable,
    input  logic                          trig_valid,
    input  logic [ID_W-1:0]               trig_id,
    input  logic [TS_W-1:0]               timestamp,
    output logic                          ser_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_cnt,
    output logic [31:0]                   frames_sent
);

    localparam int DATA_W = ID_W + TS_W;
`ifdef TRIG_TAG_TX_CRC8_EN
    localparam int CHECK_W = 8;
`else
    localparam int CHECK_W = 1;
`endif
    localparam int BAUD_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W  = $clog2(DATA_W + CHECK_W + IDLE_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CHECK_LAST = CNT_W'(CHECK_W - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

    localparam logic [2:0] ST_IDLE  = 3'(TX_IDLE);
    localparam logic [2:0] ST_START = 3'(TX_START);
    localparam logic [2:0] ST_DATA  = 3'(TX_DATA);
    localparam logic [2:0] ST_CHECK = 3'(TX_CHECK);
    localparam logic [2:0] ST_STOP  = 3'(TX_STOP);
    localparam logic [2:0] ST_GAP   = 3'(TX_GAP);

    logic [2:0]          state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CHECK_W-1:0]  check_q, check_d;
    logic                ser_out_q, ser_out_d;
    logic [31:0]         frames_q, frames_d;
    logic [15:0]         ovf_q, ovf_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_rd_data;
    logic [CHECK_W-1:0]  check_calc, check_shr;
    logic                bit_end, may_start;

    trig_tag_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_adc   (clk_adc),
        .nrst      (nrst),
        .push      (fifo_push),
        .push_data ({timestamp, trig_id}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A full FIFO still accepts a tag when the transmitter frees a slot that cycle.
    assign fifo_push = trig_valid && (!fifo_full || fifo_pop);

    always_comb begin
        ovf_d = ovf_q;
        if (trig_valid && !fifo_push && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

`ifdef TRIG_TAG_TX_CRC8_EN
    always_comb begin
        check_calc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            check_calc = crc8_next(check_calc, fifo_rd_data[i]);
        end
    end
`else
    assign check_calc = ^fifo_rd_data;
`endif

    assign bit_end   = (baud_q == BAUD_LAST);
    assign check_shr = check_q >> 1;

    // ser_out_d is always the bit for the state being entered, so the line is glitch-free.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        check_d   = check_q;
        ser_out_d = ser_out_q;
        frames_d  = frames_q;
        fifo_pop  = 1'b0;
        may_start = 1'b0;
        if (state_q != ST_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            ST_IDLE: may_start = 1'b1;
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_d     = '0;
                    ser_out_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d   = ST_CHECK;
                        bit_d     = '0;
                        ser_out_d = check_q[0];
                    end else begin
                        shift_d   = shift_q >> 1;
                        ser_out_d = shift_q[1];
                        bit_d     = bit_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (bit_end) begin
                    if (bit_q == CHECK_LAST) begin
                        state_d   = ST_STOP;
                        ser_out_d = STOP_BIT;
                    end else begin
                        check_d   = check_shr;
                        ser_out_d = check_shr[0];
                        bit_d     = bit_q + CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    frames_d = frames_q + 32'd1;
                    if (IDLE_BITS == 0) begin
                        state_d   = ST_IDLE;
                        may_start = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        bit_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        state_d   = ST_IDLE;
                        ser_out_d = 1'b0;
                        may_start = 1'b1;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Starting straight from the end of the gap keeps back-to-back frames seamless.
        if (may_start && !fifo_empty && enable) begin
            fifo_pop  = 1'b1;
            state_d   = ST_START;
            baud_d    = '0;
            bit_d     = '0;
            ser_out_d = START_BIT;
            shift_d   = fifo_rd_data;
            check_d   = check_calc;
        end
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            check_q   <= '0;
            ser_out_q <= 1'b0;
            frames_q  <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            check_q   <= check_d;
            ser_out_q <= ser_out_d;
            frames_q  <= frames_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ser_out      = ser_out_q;
    assign busy         = (state_q != ST_IDLE);
    assign overflow_cnt = ovf_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_trig_tag_tx.sv
// Randomized scoreboard bench for trig_tag_tx: a queue-level model predicts every frame,
// and a line monitor decodes ser_out independently and compares against it.
module tb_trig_tag_tx;

    localparam int ID_W       = 8;
    localparam int TS_W       = 56;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_DIV    = 4;
    localparam int IDLE_BITS  = 2;
`ifdef TRIG_TAG_TX_CRC8_EN
    localparam int CHECK_W = 8;
`else
    localparam int CHECK_W = 1;
`endif
    localparam int FRAME_BITS = ID_W + TS_W + CHECK_W + 2;
    localparam int PERIOD     = (FRAME_BITS + IDLE_BITS) * BIT_DIV;

    logic              clk_adc = 1'b0;
    logic              nrst = 1'b0;
    logic              enable = 1'b0;
    logic              trig_valid = 1'b0;
    logic [ID_W-1:0]   trig_id = '0;
    logic [TS_W-1:0]   timestamp = '0;
    logic              ser_out;
    logic              busy;
    logic [2:0]        fifo_level;
    logic [15:0]       overflow_cnt;
    logic [31:0]       frames_sent;

    trig_tag_tx #(
        .ID_W       (ID_W),
        .TS_W       (TS_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BIT_DIV    (BIT_DIV),
        .IDLE_BITS  (IDLE_BITS)
    ) dut (
        .clk_adc      (clk_adc),
        .nrst         (nrst),
        .enable       (enable),
        .trig_valid   (trig_valid),
        .trig_id      (trig_id),
        .timestamp    (timestamp),
        .ser_out      (ser_out),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .frames_sent  (frames_sent)
    );

    always #5 clk_adc = ~clk_adc;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } tag_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
        int              start;
    } frame_t;

    tag_t   pend_q[$];
    frame_t exp_q[$];
    int     done_at[$];
    int     edge_cnt = 0;
    int     line_free = 0;
    int     m_frames = 0;
    int     m_ovf = 0;
    int     errors = 0;
    int     checks = 0;
    bit     collecting = 1'b0;
    int     last_start = -1;
    int     prev_start = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Check field from its mathematical definition: parity as XOR, CRC as polynomial division.
    function automatic logic [CHECK_W-1:0] ref_check(input logic [63:0] data);
`ifdef TRIG_TAG_TX_CRC8_EN
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[71-i] = data[i];
        for (int k = 71; k >= 8; k--) begin
            if (v[k]) v[k -: 9] = v[k -: 9] ^ 9'h107;
        end
        return v[7:0];
`else
        return ^data;
`endif
    endfunction

    // Model: a tag queue plus the time the line becomes free for the next frame.
    always @(posedge clk_adc) begin
        int   c;
        bit   pop;
        tag_t t;
        c = edge_cnt;
        if (!nrst) begin
            pend_q.delete();
            done_at.delete();
            line_free = 0;
            m_frames  = 0;
            m_ovf     = 0;
        end else begin
            while (done_at.size() > 0 && done_at[0] <= c) begin
                m_frames++;
                void'(done_at.pop_front());
            end
            pop = enable && pend_q.size() > 0 && c >= line_free;
            if (pop) begin
                t = pend_q.pop_front();
                exp_q.push_back('{id: t.id, ts: t.ts, start: c + 1});
                line_free = c + PERIOD;
                done_at.push_back(c + FRAME_BITS * BIT_DIV);
            end
            if (trig_valid) begin
                if (pop || pend_q.size() < FIFO_DEPTH) pend_q.push_back('{id: trig_id, ts: timestamp});
                else if (m_ovf < 65535) m_ovf++;
            end
        end
        edge_cnt++;
    end

    // Line monitor: decode each frame seen on ser_out and compare with the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk_adc);
            if (nrst && ser_out === 1'b1) begin
                logic [FRAME_BITS-1:0] bits;
                frame_t e;
                bit     stable;
                bit     aborted;
                bit     have;
                int     st;
                st = edge_cnt;
                stable = 1'b1;
                aborted = 1'b0;
                bits = '0;
                collecting = 1'b1;
                prev_start = last_start;
                last_start = st;
                have = (exp_q.size() > 0);
                check("frame_expected", 64'(have), 64'd1);
                if (have) e = exp_q.pop_front();
                for (int k = 0; k < FRAME_BITS && !aborted; k++) begin
                    for (int j = 0; j < BIT_DIV && !aborted; j++) begin
                        if (!(k == 0 && j == 0)) @(negedge clk_adc);
                        if (!nrst) aborted = 1'b1;
                        else if (j == 0) bits[k] = ser_out;
                        else if (ser_out !== bits[k]) stable = 1'b0;
                    end
                end
                collecting = 1'b0;
                if (!aborted && have) begin
                    check("start_cycle", 64'(st), 64'(e.start));
                    check("frame_id", 64'(bits[ID_W:1]), 64'(e.id));
                    check("frame_ts", 64'(bits[ID_W+TS_W:ID_W+1]), 64'(e.ts));
                    check("frame_check", 64'(bits[ID_W+TS_W+CHECK_W:ID_W+TS_W+1]),
                          64'(ref_check({e.ts, e.id})));
                    check("frame_stop", 64'(bits[FRAME_BITS-1]), 64'd0);
                    check("bit_hold", 64'(stable), 64'd1);
                    $display("frame id=%02h ts=%014h start=%0d", bits[ID_W:1], bits[ID_W+TS_W:ID_W+1], st);
                end
            end
        end
    end

    task automatic push_tag(input logic [ID_W-1:0] id, input logic [TS_W-1:0] ts);
        @(negedge clk_adc);
        trig_valid = 1'b1;
        trig_id    = id;
        timestamp  = ts;
        @(negedge clk_adc);
        trig_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0 || collecting || edge_cnt <= line_free) && n < 20000) begin
            @(negedge clk_adc);
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < 20000), 64'd1);
        repeat (2) @(negedge clk_adc);
        check({name, "_frames_sent"}, 64'(frames_sent), 64'(m_frames));
        check({name, "_fifo_level"}, 64'(fifo_level), 64'(pend_q.size()));
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        nrst = 1'b0;
        repeat (3) @(negedge clk_adc);
        check("rst_ser_out", 64'(ser_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow_cnt), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        nrst = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk_adc);

        // Single tag and its start latency.
        trig_id = 8'h05;
        timestamp = 56'h1;
        trig_valid = 1'b1;
        @(negedge clk_adc);
        trig_valid = 1'b0;
        check("lat_cycle1_low", 64'(ser_out), 64'd0);
        @(negedge clk_adc);
        check("lat_cycle2_high", 64'(ser_out), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        drain("single");
        check("single_frames_one", 64'(frames_sent), 64'd1);

        push_tag(8'h01, 56'h0);
        drain("parity");

        // Random tags, random spacing, enable toggling.
        for (int i = 0; i < 8; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
            repeat ($urandom_range(0, 150)) @(negedge clk_adc);
        end
        enable = 1'b1;
        drain("random");

        // Burst of six consecutive pulses from idle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_adc);
            trig_valid = 1'b1;
            trig_id    = 8'($urandom());
            timestamp  = 56'({$urandom(), $urandom()});
        end
        @(negedge clk_adc);
        trig_valid = 1'b0;
        check("burst_level", 64'(fifo_level), 64'd4);
        check("burst_overflow", 64'(overflow_cnt), 64'(m_ovf));
        drain("burst");

        // Queue held while disabled, then released back-to-back.
        enable = 1'b0;
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clk_adc);
            check("hold_ser_out", 64'(ser_out), 64'd0);
        end
        check("hold_level", 64'(fifo_level), 64'd2);
        check("hold_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        drain("release");
        check("release_spacing", 64'(last_start - prev_start), 64'(PERIOD));

        // Disable mid-frame: current frame completes, the queued tag waits.
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        repeat (100) @(negedge clk_adc);
        enable = 1'b0;
        repeat (PERIOD) @(negedge clk_adc);
        check("midoff_busy", 64'(busy), 64'd0);
        check("midoff_level", 64'(fifo_level), 64'd1);
        check("midoff_frames", 64'(frames_sent), 64'(m_frames));
        enable = 1'b1;
        drain("midoff");

        // Asynchronous reset in the middle of the data field.
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        push_tag(8'($urandom()), 56'({$urandom(), $urandom()}));
        repeat (40) @(negedge clk_adc);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_ser_out", 64'(ser_out), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_overflow", 64'(overflow_cnt), 64'd0);
        check("arst_frames", 64'(frames_sent), 64'd0);
        repeat (2) @(negedge clk_adc);
        nrst = 1'b1;
        push_tag(8'hA7, 56'h00_1234_5678_9ABC);
        drain("post_reset");

        // Overflow saturation with the queue held full.
        enable = 1'b0;
        @(negedge clk_adc);
        trig_valid = 1'b1;
        trig_id    = 8'($urandom());
        timestamp  = 56'({$urandom(), $urandom()});
        repeat (4 + 65533) @(negedge clk_adc);
        check("sat_near", 64'(overflow_cnt), 64'hFFFD);
        check("sat_near_model", 64'(overflow_cnt), 64'(m_ovf));
        repeat (3) @(negedge clk_adc);
        trig_valid = 1'b0;
        check("sat_top", 64'(overflow_cnt), 64'hFFFF);
        repeat (2) @(negedge clk_adc);
        check("sat_hold", 64'(overflow_cnt), 64'hFFFF);
        check("sat_level", 64'(fifo_level), 64'd4);
        enable = 1'b1;
        drain("sat");

        check("leftover_frames", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
